// File: rtl/round_ctrl.sv
// Round sequencer for the 2-player factorization match: question request,
// answer arbitration, outcome pulses to the HP manager, match-end detection.
// Optional: define TIE_BREAK_EN to resolve simultaneous correct answers by alternating priority.
module round_ctrl #(
  parameter int unsigned ANS_TIMEOUT = 1000,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned GAP_CYC     = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Q_READY,
  input  logic       P1_VALID,
  input  logic       P1_OK,
  input  logic       P2_VALID,
  input  logic       P2_OK,
  input  logic [1:0] RESULT,
  output logic       HP_CLR,
  output logic       Q_REQ,
  output logic [1:0] OUTCOME,
  output logic [7:0] ROUND_CNT,
  output logic       MATCH_OVER,
  output logic [1:0] WINNER
);

  localparam int unsigned M1   = (ANS_TIMEOUT > HOLD_CYC) ? ANS_TIMEOUT : HOLD_CYC;
  localparam int unsigned MAXC = (M1 > GAP_CYC) ? M1 : GAP_CYC;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] ANS_LAST  = CW'(ANS_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_P1   = 2'b10;
  localparam logic [1:0] C_P2   = 2'b01;
  localparam logic [1:0] C_DRAW = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_QREQ, S_ANSWER, S_REPORT, S_GAP, S_CHECK, S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_lock1;
  logic            r_lock2;
  logic [1:0]      r_latch;
  logic            r_hp_clr;
  logic            r_q_req;
  logic [1:0]      r_outcome;
  logic [7:0]      r_round_cnt;
  logic            r_match_over;
  logic [1:0]      r_winner;
`ifdef TIE_BREAK_EN
  logic            r_prio;      // 0: P1 wins next tie, 1: P2 wins next tie
`endif

  logic       w_p1_ok;
  logic       w_p1_bad;
  logic       w_p2_ok;
  logic       w_p2_bad;
  logic       w_tie;
  logic       w_lock1_nx;
  logic       w_lock2_nx;
  logic       w_res_hit;
  logic [1:0] w_latch_nx;
  logic [1:0] w_tie_code;
  logic       w_ans_done;
  logic [1:0] w_ans_code;

  assign w_p1_ok    = P1_VALID &  P1_OK & ~r_lock1;
  assign w_p1_bad   = P1_VALID & ~P1_OK & ~r_lock1;
  assign w_p2_ok    = P2_VALID &  P2_OK & ~r_lock2;
  assign w_p2_bad   = P2_VALID & ~P2_OK & ~r_lock2;
  assign w_tie      = w_p1_ok & w_p2_ok;
  assign w_lock1_nx = r_lock1 | w_p1_bad;
  assign w_lock2_nx = r_lock2 | w_p2_bad;

  // First valid RESULT wins; 11 is not a match result. Includes the CHECK cycle itself.
  assign w_res_hit  = (RESULT == C_P1) || (RESULT == C_P2);
  assign w_latch_nx = (r_latch != C_NONE) ? r_latch : (w_res_hit ? RESULT : C_NONE);

`ifdef TIE_BREAK_EN
  assign w_tie_code = r_prio ? C_P2 : C_P1;
`else
  assign w_tie_code = C_DRAW;
`endif

  always_comb begin
    w_ans_done = 1'b0;
    w_ans_code = C_NONE;
    if (w_tie) begin
      w_ans_done = 1'b1;
      w_ans_code = w_tie_code;
    end else if (w_p1_ok) begin
      w_ans_done = 1'b1;
      w_ans_code = C_P1;
    end else if (w_p2_ok) begin
      w_ans_done = 1'b1;
      w_ans_code = C_P2;
    end else if ((w_lock1_nx & w_lock2_nx) || (r_cnt == ANS_LAST)) begin
      w_ans_done = 1'b1;
      w_ans_code = C_DRAW;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lock1      <= 1'b0;
      r_lock2      <= 1'b0;
      r_latch      <= '0;
      r_hp_clr     <= 1'b0;
      r_q_req      <= 1'b0;
      r_outcome    <= '0;
      r_round_cnt  <= '0;
      r_match_over <= 1'b0;
      r_winner     <= '0;
`ifdef TIE_BREAK_EN
      r_prio       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_state      <= S_CLR;
            r_hp_clr     <= 1'b1;
            r_round_cnt  <= '0;
            r_winner     <= '0;
            r_latch      <= '0;
            r_match_over <= 1'b0;
`ifdef TIE_BREAK_EN
            r_prio       <= 1'b0;
`endif
          end
        end
        S_CLR: begin
          r_hp_clr <= 1'b0;
          r_q_req  <= 1'b1;
          r_state  <= S_QREQ;
        end
        S_QREQ: begin
          if (Q_READY) begin
            r_q_req <= 1'b0;
            r_cnt   <= '0;
            r_lock1 <= 1'b0;
            r_lock2 <= 1'b0;
            r_state <= S_ANSWER;
          end
        end
        S_ANSWER: begin
          if (w_ans_done) begin
            r_outcome <= w_ans_code;
            if (r_round_cnt != '1)
              r_round_cnt <= r_round_cnt + 8'd1;
            r_cnt     <= '0;
            r_state   <= S_REPORT;
`ifdef TIE_BREAK_EN
            if (w_tie)
              r_prio <= ~r_prio;
`endif
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_lock1 <= w_lock1_nx;
            r_lock2 <= w_lock2_nx;
          end
        end
        S_REPORT: begin
          r_latch <= w_latch_nx;
          if (r_cnt == HOLD_LAST) begin
            r_outcome <= C_NONE;
            r_cnt     <= '0;
            r_state   <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          r_latch <= w_latch_nx;
          if (r_cnt == GAP_LAST)
            r_state <= S_CHECK;
          else
            r_cnt <= r_cnt + 1'b1;
        end
        S_CHECK: begin
          r_latch <= w_latch_nx;
          if (w_latch_nx != C_NONE) begin
            r_winner     <= w_latch_nx;
            r_match_over <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_q_req <= 1'b1;
            r_state <= S_QREQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign HP_CLR     = r_hp_clr;
  assign Q_REQ      = r_q_req;
  assign OUTCOME    = r_outcome;
  assign ROUND_CNT  = r_round_cnt;
  assign MATCH_OVER = r_match_over;
  assign WINNER     = r_winner;

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: stimulus pushes expected outcomes/winners,
// a negedge monitor pops and compares when OUTCOME or MATCH_OVER rises.
module tb_round_ctrl;

  localparam int HOLD = 4;

  logic       CLK = 1'b0;
  logic       RST, START, Q_READY, P1_VALID, P1_OK, P2_VALID, P2_OK;
  logic [1:0] RESULT;
  logic       HP_CLR, Q_REQ, MATCH_OVER;
  logic [1:0] OUTCOME, WINNER;
  logic [7:0] ROUND_CNT;

  round_ctrl #(.ANS_TIMEOUT(1000), .HOLD_CYC(4), .GAP_CYC(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .Q_READY(Q_READY),
    .P1_VALID(P1_VALID), .P1_OK(P1_OK), .P2_VALID(P2_VALID), .P2_OK(P2_OK),
    .RESULT(RESULT), .HP_CLR(HP_CLR), .Q_REQ(Q_REQ), .OUTCOME(OUTCOME),
    .ROUND_CNT(ROUND_CNT), .MATCH_OVER(MATCH_OVER), .WINNER(WINNER)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] rcnt;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] wq[$];
  int checks = 0;
  int errors = 0;

`ifdef TIE_BREAK_EN
  localparam logic [1:0] TIE1 = 2'b10;
  localparam logic [1:0] TIE2 = 2'b01;
`else
  localparam logic [1:0] TIE1 = 2'b11;
  localparam logic [1:0] TIE2 = 2'b11;
`endif

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_out(input bit want_nz, input int budget, input string name);
    int n = 0;
    while (((OUTCOME != 2'b00) != want_nz) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if ((OUTCOME != 2'b00) != want_nz) begin
      errors++;
      $display("FAIL %s: timed out after %0d cycles, OUTCOME=%b", name, n, OUTCOME);
    end
  endtask

  task automatic get_question();
    int n = 0;
    while (!Q_REQ && n < 30) begin
      tick();
      n++;
    end
    chk("q_req_seen", {7'd0, Q_REQ}, 8'd1);
    idle(3);
    Q_READY = 1'b1;
    tick();
    Q_READY = 1'b0;
    chk("q_req_drop", {7'd0, Q_REQ}, 8'd0);
  endtask

  task automatic ans(input logic p1v, input logic p1ok, input logic p2v, input logic p2ok);
    P1_VALID = p1v; P1_OK = p1ok; P2_VALID = p2v; P2_OK = p2ok;
    tick();
    P1_VALID = 1'b0; P1_OK = 1'b0; P2_VALID = 1'b0; P2_OK = 1'b0;
  endtask

  task automatic push(input logic [1:0] code, input logic [7:0] rcnt);
    exp_t e;
    e.code = code;
    e.rcnt = rcnt;
    sb.push_back(e);
  endtask

  task automatic start_match();
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("hp_clr_pulse", {7'd0, HP_CLR}, 8'd1);
    chk("clr_round_cnt", ROUND_CNT, 8'd0);
    chk("clr_winner", {6'd0, WINNER}, 8'd0);
    chk("clr_match_over", {7'd0, MATCH_OVER}, 8'd0);
    tick();
    chk("hp_clr_end", {7'd0, HP_CLR}, 8'd0);
  endtask

  // Monitor: compares each fresh 00->code edge and each match end against the queues.
  logic [1:0] prev_out = 2'b00;
  logic       prev_mo  = 1'b0;
  int         run      = 0;
  exp_t       me;
  logic [1:0] mw;

  always @(negedge CLK) begin
    if (RST) begin
      prev_out = 2'b00;
      prev_mo  = 1'b0;
      run      = 0;
    end else begin
      if (OUTCOME != 2'b00) begin
        if (prev_out == 2'b00) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL outcome_unexpected: got %b, expected no outcome", OUTCOME);
          end else begin
            me = sb.pop_front();
            chk("outcome_code", {6'd0, OUTCOME}, {6'd0, me.code});
            chk("round_cnt", ROUND_CNT, me.rcnt);
          end
          run = 1;
        end else begin
          run++;
        end
      end else if (prev_out != 2'b00) begin
        chk("hold_len", 8'(run), 8'(HOLD));
      end
      prev_out = OUTCOME;
      if (MATCH_OVER && !prev_mo) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL match_over_unexpected: got WINNER=%b, expected no match end", WINNER);
        end else begin
          mw = wq.pop_front();
          chk("winner", {6'd0, WINNER}, {6'd0, mw});
        end
      end
      prev_mo = MATCH_OVER;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; START = 1'b0; Q_READY = 1'b0; RESULT = 2'b00;
    P1_VALID = 1'b0; P1_OK = 1'b0; P2_VALID = 1'b0; P2_OK = 1'b0;
    idle(3);
    chk("rst_outcome", {6'd0, OUTCOME}, 8'd0);
    chk("rst_flags", {4'd0, HP_CLR, Q_REQ, MATCH_OVER, 1'b0}, 8'd0);
    chk("rst_round_cnt", ROUND_CNT, 8'd0);
    chk("rst_winner", {6'd0, WINNER}, 8'd0);
    RST = 1'b0;
    tick();

    // Q_READY in IDLE must not start anything.
    Q_READY = 1'b1;
    tick();
    Q_READY = 1'b0;
    tick();
    chk("idle_qready_ignored", {6'd0, Q_REQ, HP_CLR}, 8'd0);

    // Match 1
    start_match();
    chk("q_req_after_clr", {7'd0, Q_REQ}, 8'd1);

    // Round 1: P1 correct immediately
    get_question();
    push(2'b10, 8'd1);
    ans(1, 1, 0, 0);
    wait_out(0, 20, "r1_end");

    // Round 2: P2 wrong at 5 (locked), P2 correct at 8 ignored, P1 correct at 12
    get_question();
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("start_in_answer_ignored", {7'd0, HP_CLR}, 8'd0);
    idle(4);
    ans(0, 0, 1, 0);
    idle(2);
    ans(0, 0, 1, 1);
    chk("locked_p2_ignored", {6'd0, OUTCOME}, 8'd0);
    idle(3);
    push(2'b10, 8'd2);
    ans(1, 1, 0, 0);
    wait_out(0, 20, "r2_end");

    // Rounds 3, 4: simultaneous correct
    get_question();
    push(TIE1, 8'd3);
    ans(1, 1, 1, 1);
    wait_out(0, 20, "r3_end");
    get_question();
    idle(1);
    push(TIE2, 8'd4);
    ans(1, 1, 1, 1);
    wait_out(0, 20, "r4_end");

    // Round 5: both wrong same cycle -> immediate draw
    get_question();
    idle(2);
    push(2'b11, 8'd5);
    ans(1, 0, 1, 0);
    chk("both_wrong_immediate", {6'd0, OUTCOME}, 8'h03);
    wait_out(0, 20, "r5_end");

    // Round 6: timeout, then RESULT=11 in GAP must be ignored
    get_question();
    push(2'b11, 8'd6);
    idle(999);
    chk("timeout_not_early", {6'd0, OUTCOME}, 8'd0);
    tick();
    chk("timeout_at_1000", {6'd0, OUTCOME}, 8'h03);
    wait_out(0, 20, "r6_end");
    idle(2);
    RESULT = 2'b11;
    tick();
    RESULT = 2'b00;
    idle(6);
    chk("result11_no_done", {7'd0, MATCH_OVER}, 8'd0);
    chk("result11_next_qreq", {7'd0, Q_REQ}, 8'd1);

    // Round 7: P1 wrong and P2 correct same cycle; RESULT=10 pulse in GAP ends match
    get_question();
    push(2'b01, 8'd7);
    ans(1, 0, 1, 1);
    wait_out(0, 20, "r7_end");
    idle(2);
    wq.push_back(2'b10);
    RESULT = 2'b10;
    tick();
    RESULT = 2'b00;
    idle(5);
    chk("done_not_early", {7'd0, MATCH_OVER}, 8'd0);
    tick();
    chk("match_over", {7'd0, MATCH_OVER}, 8'd1);
    chk("done_winner", {6'd0, WINNER}, 8'h02);
    idle(3);
    chk("done_no_qreq", {7'd0, Q_REQ}, 8'd0);

    // Match 2: reset during REPORT
    start_match();
    get_question();
    push(2'b10, 8'd1);
    ans(1, 1, 0, 0);
    tick();
    RST = 1'b1;
    #1;
    chk("rst_mid_outcome", {6'd0, OUTCOME}, 8'd0);
    chk("rst_mid_flags", {5'd0, HP_CLR, Q_REQ, MATCH_OVER}, 8'd0);
    chk("rst_mid_round_cnt", ROUND_CNT, 8'd0);
    tick();
    RST = 1'b0;
    idle(2);
    chk("rst_mid_idle", {6'd0, Q_REQ, HP_CLR}, 8'd0);

    // Match 3: behaves as a fresh match; run past 255 rounds to exercise saturation
    start_match();
    for (int n = 1; n <= 257; n++) begin
      get_question();
      if (n % 2 == 1) begin
        push(2'b10, (n > 255) ? 8'd255 : 8'(n));
        ans(1, 1, 0, 0);
      end else begin
        push(2'b01, (n > 255) ? 8'd255 : 8'(n));
        ans(0, 0, 1, 1);
      end
      wait_out(0, 20, "sat_round_end");
    end
    chk("round_cnt_saturated", ROUND_CNT, 8'd255);

    idle(2);
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    chk("winner_queue_drained", 8'(wq.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
